// File: rtl/ram_loader_pkg.sv
// Shared constants and state encoding for the RAM boot loader.
// The RAM geometry constants are also used by the RAM and the CPU top level.
package ram_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 16384;

  // state  | meaning
  // IDLE    | pass-through, waiting for start
  // LEN_HI  | expecting length high byte
  // LEN_LO  | expecting length low byte
  // DATA_HI | expecting high byte of a data word
  // DATA_LO | expecting low byte of a data word
  // CHECK   | expecting checksum byte
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5
  } state_t;

endpackage

// File: rtl/ram_port_mux.sv
// Combinational select between two RAM write sources.
// Ports:
//   sel              1 selects source A, 0 selects source B
//   a_in/a_load/a_address   source A write path
//   b_in/b_load/b_address   source B write path
//   y_in/y_load/y_address   selected write path to the RAM
module ram_port_mux
  import ram_loader_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_load,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_load,
  input  logic [ADDR_W-1:0] b_address,
  output logic [DATA_W-1:0] y_in,
  output logic              y_load,
  output logic [ADDR_W-1:0] y_address
);

  assign y_in      = sel ? a_in      : b_in;
  assign y_load    = sel ? a_load    : b_load;
  assign y_address = sel ? a_address : b_address;

endmodule

// File: rtl/ram_loader.sv
// Boot-time program loader in front of the 16K x 16 RAM.
// Accepts a framed byte stream (LEN_HI, LEN_LO, N x {hi, lo}, checksum),
// writes the words to RAM addresses 0..N-1 and holds the CPU meanwhile.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       arms the loader when idle
//   in_data/in_valid/in_ready   byte stream handshake
//   cpu_in/cpu_load/cpu_address CPU write path, passed through when idle
//   ram_in/ram_load/ram_address RAM write path
//   cpu_hold, busy              frame in progress
//   done, error                 sticky frame result
module ram_loader
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_t              state, state_n;
  logic [BYTE_W-1:0]   len_hi, data_hi, csum;
  logic [14:0]         len, word_cnt;
  logic [15:0]         len_n;
  logic                take, last_word;
  logic                wr_pend;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   wr_addr;

  assign busy      = (state != IDLE);
  assign cpu_hold  = busy;
  assign in_ready  = busy;
  assign take      = in_valid & in_ready;
  assign len_n     = {len_hi, in_data};
  assign last_word = ((word_cnt + 15'd1) == len);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LEN_HI;
      LEN_HI:  if (take)  state_n = LEN_LO;
      LEN_LO:
        if (take) begin
          if (len_n == 16'd0)        state_n = CHECK;
          else if (len_n > MAX_LEN)  state_n = IDLE;
          else                       state_n = DATA_HI;
        end
      DATA_HI: if (take)  state_n = DATA_LO;
      DATA_LO: if (take)  state_n = last_word ? CHECK : DATA_HI;
      CHECK:   if (take)  state_n = IDLE;
      default:            state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_hi   <= '0;
      data_hi  <= '0;
      csum     <= '0;
      len      <= '0;
      word_cnt <= '0;
      wr_pend  <= 1'b0;
      wr_data  <= '0;
      wr_addr  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state   <= state_n;
      wr_pend <= 1'b0;
      if (state == IDLE && start) begin
        done     <= 1'b0;
        error    <= 1'b0;
        word_cnt <= '0;
        csum     <= '0;
      end
      if (take) begin
        case (state)
          LEN_HI: begin
            len_hi <= in_data;
            csum   <= csum + in_data;
          end
          LEN_LO: begin
            len  <= len_n[14:0];
            csum <= csum + in_data;
            if (len_n > MAX_LEN) error <= 1'b1;
          end
          DATA_HI: begin
            data_hi <= in_data;
            csum    <= csum + in_data;
          end
          DATA_LO: begin
            // Registered write, issued in the cycle after the low byte.
            wr_pend  <= 1'b1;
            wr_data  <= {data_hi, in_data};
            wr_addr  <= word_cnt[ADDR_W-1:0];
            word_cnt <= word_cnt + 15'd1;
            csum     <= csum + in_data;
          end
          CHECK: begin
            if (in_data == csum) done  <= 1'b1;
            else                 error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // While busy the loader owns the RAM port; between its writes it drives load low.
  ram_port_mux u_mux (
    .sel       (busy | wr_pend),
    .a_in      (wr_data),
    .a_load    (wr_pend),
    .a_address (wr_addr),
    .b_in      (cpu_in),
    .b_load    (cpu_load),
    .b_address (cpu_address),
    .y_in      (ram_in),
    .y_load    (ram_load),
    .y_address (ram_address)
  );

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_ready;
  logic [7:0]        in_data;
  logic [15:0]       cpu_in, ram_in;
  logic              cpu_load, ram_load;
  logic [13:0]       cpu_address, ram_address;
  logic              cpu_hold, busy, done, error;

  typedef struct packed {
    logic [13:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:16383];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {18'd0, ram_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {18'd0, ram_address}, {18'd0, e.a});
        check("write_data", {16'd0, ram_in}, {16'd0, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) check("handshake_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b); in_valid = 1'b0; tick();
  endtask

  task automatic push(input logic [13:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_in = 16'h1357; cpu_load = 1'b0; cpu_address = 14'd3;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    check("rst_ram_addr", {18'd0, ram_address}, 32'd3);
    check("rst_ram_in",   {16'd0, ram_in},      32'h1357);
    tick(); reset = 1'b0; tick();

    // Idle pass-through writes; idle bytes are not consumed.
    push(14'd7, 16'h5A5A);
    cpu_load = 1'b1; cpu_address = 14'd7; cpu_in = 16'h5A5A;
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    push(14'd100, 16'h0F0F);
    cpu_address = 14'd100; cpu_in = 16'h0F0F;
    tick();
    cpu_load = 1'b0; in_valid = 1'b0;
    check("pt_mem7",   {16'd0, mem[7]},   32'h5A5A);
    check("pt_mem100", {16'd0, mem[100]}, 32'h0F0F);

    // Good frame, back-to-back bytes.
    push(14'd0, 16'h1234); push(14'd1, 16'hABCD);
    pulse_start();
    check("busy_after_start", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'hC0);
    in_valid = 1'b0;
    check("good_done",  {31'd0, done},  32'd1);
    check("good_error", {31'd0, error}, 32'd0);
    check("good_busy",  {31'd0, busy},  32'd0);
    check("good_ready", {31'd0, in_ready}, 32'd0);
    check("good_mem0",  {16'd0, mem[0]}, 32'h1234);
    check("good_mem1",  {16'd0, mem[1]}, 32'hABCD);
    check("good_q",     exp_q.size(), 32'd0);
    tick();

    // Bad checksum: data stays in RAM, error flagged.
    push(14'd0, 16'h1234); push(14'd1, 16'hABCD);
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'hC1);
    in_valid = 1'b0;
    check("badck_done",  {31'd0, done},  32'd0);
    check("badck_error", {31'd0, error}, 32'd1);
    check("badck_q",     exp_q.size(), 32'd0);
    tick();

    // Oversize length 16385.
    pulse_start();
    check("ovs_done_cleared", {31'd0, error}, 32'd0);
    send_byte(8'h40); send_byte(8'h01);
    in_valid = 1'b0;
    check("ovs_error", {31'd0, error},    32'd1);
    check("ovs_busy",  {31'd0, busy},     32'd0);
    check("ovs_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();

    // Zero length with gaps between bytes.
    pulse_start();
    send_gap(8'h00); send_gap(8'h00);
    check("zero_busy_mid", {31'd0, busy}, 32'd1);
    send_gap(8'h00);
    check("zero_done",  {31'd0, done},  32'd1);
    check("zero_error", {31'd0, error}, 32'd0);
    check("zero_busy",  {31'd0, busy},  32'd0);

    // Start while busy must not disturb counters or checksum.
    push(14'd0, 16'h1234);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'h34); send_byte(8'h47);
    in_valid = 1'b0;
    check("swb_done",  {31'd0, done},  32'd1);
    check("swb_error", {31'd0, error}, 32'd0);
    check("swb_mem0",  {16'd0, mem[0]}, 32'h1234);
    tick();

    // Reset mid-frame.
    push(14'd0, 16'h1122);
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_busy",  {31'd0, busy},  32'd0);
    check("mid_rst_done",  {31'd0, done},  32'd0);
    check("mid_rst_error", {31'd0, error}, 32'd0);
    check("mid_rst_load",  {31'd0, ram_load}, 32'd0);
    tick(); tick();
    push(14'd5, 16'hBEEF);
    cpu_load = 1'b1; cpu_address = 14'd5; cpu_in = 16'hBEEF;
    tick();
    cpu_load = 1'b0;
    check("mid_rst_mem5", {16'd0, mem[5]}, 32'hBEEF);
    check("mid_rst_mem0", {16'd0, mem[0]}, 32'h1122);

    // Simultaneous reset and start: reset wins.
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_start_busy2", {31'd0, busy}, 32'd0);
    check("final_q", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time program loader that sits directly upstream of the 16K x 16 data/program RAM and drives its in/load/address inputs.
- Receives a framed byte stream, for example from the UART receiver, over a valid/ready handshake.
- Assembles the bytes into 16-bit words and writes them into consecutive RAM addresses starting at 0.
- While idle, it passes the CPU's RAM write path straight through. While loading, it holds the CPU.

Parameters:
- ADDR_W, 14, RAM address width (2^14 words).
- DATA_W, 16, RAM word width; exactly two bytes per word.
- MAX_WORDS, 16384, largest accepted length field.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that arms the loader; ignored while busy.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle. A byte is consumed when in_valid && in_ready.
- cpu_in  input  16  CPU write data, passed through when idle.
- cpu_load  input  1  CPU write enable, passed through when idle.
- cpu_address  input  14  CPU address, passed through when idle.
- ram_in  output  16  to RAM data input.
- ram_load  output  1  to RAM write enable.
- ram_address  output  14  to RAM address.
- cpu_hold  output  1  stalls the CPU; equals busy.
- busy  output  1  frame in progress.
- done  output  1  sticky; last frame completed with a good checksum.
- error  output  1  sticky; last frame had a bad length or bad checksum.

Behaviour:
- Frame format: LEN_HI, LEN_LO (N words, big-endian), then N words of 2 bytes each (high byte first), then 1 checksum byte.
- The checksum byte must equal the mod-256 sum of all length bytes and data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
  - IDLE -> LEN_HI on start. The start cycle also clears done, error, the word counter and the checksum accumulator.
  - Each state advances only on a byte handshake.
  - LEN_LO -> DATA_HI if 1 <= N <= MAX_WORDS.
  - LEN_LO -> CHECK if N = 0 (nothing is written).
  - LEN_LO -> IDLE with error=1 if N > MAX_WORDS.
  - DATA_HI -> DATA_LO.
  - DATA_LO -> DATA_HI while words remain; otherwise DATA_LO -> CHECK.
  - CHECK -> IDLE, setting done=1 on a checksum match or error=1 on a mismatch.
- in_ready = 1 in every state except IDLE. Bytes presented in IDLE are not consumed.
- busy = (state != IDLE); cpu_hold = busy.
- RAM write timing: the write is registered.
  - The cycle after the DATA_LO handshake drives ram_load=1, ram_address=word index, ram_in={hi,lo}. This lasts exactly one cycle.
  - The next byte may be accepted in that same cycle; back-to-back bytes give full throughput of 1 word per 2 cycles.
- Word index starts at 0 and increments after each write. It never exceeds N-1 <= 16383, so no wrap can occur.
- Output mux: when busy=0 or in the final write cycle, the loader-side rule applies as follows.
  - If the loader's own registered write is pending, it takes priority. The CPU is held during that cycle regardless, so cpu_hold stays 1 until the write cycle ends.
  - Otherwise ram_in/ram_load/ram_address = cpu_in/cpu_load/cpu_address combinationally.
- Checksum mismatch does not roll back written words; RAM keeps the data and error flags the frame as bad.
- A start pulse while busy is ignored.
- Reset (any state, mid-frame included) has the following effect:
  - state=IDLE, all counters=0, done=0, error=0, pending write cancelled.
  - The next cycle shows ram_load = cpu_load (pass-through).
  - Partially written RAM is left unchanged.
- Reset values of the outputs: in_ready=0, busy=0, cpu_hold=0, done=0, error=0. ram_* are pass-through of the cpu_* inputs.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE..CHECK);
  - BYTE_W=8;
  - RAM geometry constants ADDR_W/DATA_W/MAX_WORDS, also used by the RAM and CPU top level.
- Keep the frame FSM, counters and checksum in ram_loader.
- One natural sub-module: ram_port_mux, the combinational 3-signal select between the loader and CPU write paths. It is reused later for a DMA source.

Test Plan:
- Good frame: start, then bytes 00 02 12 34 AB CD C0 with in_valid held high -> RAM[0]=0x1234, RAM[1]=0xABCD. Two single-cycle ram_load pulses. done=1, error=0, busy drops after the C0 handshake.
- Bad checksum: same frame with a last byte of 0xC1 -> both words written, error=1, done=0.
- Oversize length: start, then 40 01 (N=16385) -> no ram_load pulse, error=1 after the second byte, in_ready=0 afterwards.
- Zero length with gaps: start, then 00 00 00 with in_valid toggled every other cycle -> no writes, done=1; every byte consumed only on valid&&ready.
- Reset mid-frame: start, 00 03 11 22 33, assert reset for one cycle -> busy=0, done=error=0, no further writes. RAM[0]=0x1122 retained. Pass-through then resumes: cpu_load=1, cpu_address=5, cpu_in=0xBEEF -> RAM[5]=0xBEEF.
- Pass-through and start-while-busy: idle CPU writes reach the RAM unchanged. A start pulse mid-frame does not reset the counters or the checksum.
